// File: rtl/mips_divider_pkg.sv
// Shared definitions for the MIPS DIV/DIVU iterative divider:
// the default datapath width and the controller state encoding.
package mips_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/mips_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits and record the
// quotient bit. Purely combinational.
module mips_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_p,  // partial remainder, always < i_d
  input  logic [WIDTH-1:0] i_q,  // remaining dividend bits / quotient so far
  input  logic [WIDTH-1:0] i_d,  // divisor magnitude
  output logic [WIDTH-1:0] o_p,
  output logic [WIDTH-1:0] o_q
);

  // The shifted remainder needs one extra bit; after the conditional
  // subtract the result is again below i_d and fits in WIDTH bits.
  logic [WIDTH:0] w_shift;
  logic           w_ge;

  assign w_shift = {i_p, i_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, i_d});
  assign o_p     = w_ge ? (w_shift[WIDTH-1:0] - i_d) : w_shift[WIDTH-1:0];
  assign o_q     = {i_q[WIDTH-2:0], w_ge};

endmodule

// File: rtl/mips_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU. Produces the LO
// (quotient) and HI (remainder) values one quotient bit per cycle.
// Handshake: start is accepted only while busy is low (IDLE or DONE);
// operands are sampled on the accepting edge. done pulses for exactly
// one cycle when quotient/remainder/div_by_zero carry the new result,
// and those outputs then hold until the next result is written.
// flush aborts any operation without a done pulse and wins over start.
module mips_divider
  import mips_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [CNT_W-1:0] r_cnt;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH-1:0] w_p_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_can_accept;

  // Magnitudes for the unsigned core; the most negative value maps to
  // 2^(WIDTH-1), which is still representable as an unsigned magnitude.
  assign w_a_neg      = is_signed & dividend[WIDTH-1];
  assign w_b_neg      = is_signed & divisor[WIDTH-1];
  assign w_a_abs      = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_abs      = w_b_neg ? (~divisor + 1'b1) : divisor;
  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE);

  mips_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_p (r_p),
    .i_q (r_q),
    .i_d (r_d),
    .o_p (w_p_next),
    .o_q (w_q_next)
  );

  // Controller, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_p     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
    end else if (flush) begin
      // Abort: results keep whatever the last completed divide wrote.
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && w_can_accept) begin
            if (divisor == '0) begin
              // No iteration needed: publish the MIPS-style fixed result.
              r_quo   <= '1;
              r_rem   <= dividend;
              r_dz    <= 1'b1;
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_p     <= '0;
              r_q     <= w_a_abs;
              r_d     <= w_b_abs;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_cnt   <= CNT_W'(WIDTH - 1);
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          // Quotient sign follows the operand signs, remainder follows
          // the dividend; the overflow case wraps to the most negative value.
          r_quo   <= r_neg_q ? (~r_q + 1'b1) : r_q;
          r_rem   <= r_neg_r ? (~r_p + 1'b1) : r_p;
          r_dz    <= 1'b0;
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dz;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mips_divider.sv
// Bench for mips_divider: directed literal cases plus a randomized
// stream, all compared every cycle against a latency/arithmetic model.
module tb_mips_divider;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } res_t;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         flush;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .flush       (flush),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // ---------------- reference arithmetic ----------------
  function automatic res_t model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic s);
    res_t res;
    int   sa;
    int   sb;
    sa = a;
    sb = b;
    res.dz = 1'b0;
    if (b == '0) begin
      res.q  = '1;
      res.r  = a;
      res.dz = 1'b1;
    end else if (!s) begin
      res.q = a / b;
      res.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res.q = 32'h8000_0000;
      res.r = '0;
    end else begin
      res.q = sa / sb;
      res.r = sa % sb;
    end
    return res;
  endfunction

  // ---------------- cycle model and scoreboard ----------------
  logic chk_en = 1'b0;
  logic m_done = 1'b0;
  int   m_left = 0;
  res_t m_res  = '0;
  res_t exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = '0;
      exp_q.delete();
      chk_en = 1'b1;
    end else if (flush) begin
      m_left = 0;
      m_done = 1'b0;
      exp_q.delete();
    end else if (start && m_left == 0) begin
      if (divisor == '0) begin
        m_res  = model_div(dividend, divisor, is_signed);
        m_done = 1'b1;
      end else begin
        exp_q.push_back(model_div(dividend, divisor, is_signed));
        m_left = LAT - 1;
        m_done = 1'b0;
      end
    end else if (m_left > 0) begin
      m_left--;
      m_done = 1'b0;
      if (m_left == 0 && exp_q.size() > 0) begin
        m_res  = exp_q.pop_front();
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (busy !== (m_left > 0) || done !== m_done || quotient !== m_res.q ||
          remainder !== m_res.r || div_by_zero !== m_res.dz) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got busy=%b done=%b q=%h r=%h dz=%b want busy=%b done=%b q=%h r=%h dz=%b",
                 $time, busy, done, quotient, remainder, div_by_zero,
                 (m_left > 0), m_done, m_res.q, m_res.r, m_res.dz);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int bcnt);
    lat  = lat0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      next_cycle();
      lat++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout got=no_done want=done_within_100");
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input int elat);
    int lat;
    int bcnt;
    next_cycle();
    issue(a, b, s);
    wait_done(1, lat, bcnt);
    check({name, "_lat"}, lat, elat);
    check({name, "_busy_cycles"}, bcnt, elat - 1);
    check({name, "_q"}, quotient, eq);
    check({name, "_r"}, remainder, er);
    check({name, "_dz"}, {31'd0, div_by_zero}, {31'd0, edz});
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      4:       return 32'd0 - $urandom_range(1, 20);
      5:       return 32'd1;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    res_t pin;
    int   lat;
    int   bcnt;
    int   saw_done;

    rst = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) next_cycle();
    rst = 1'b0;

    // Hand-computed values pinning the model itself.
    pin = model_div(32'd100, 32'd7, 1'b0);
    check("model_divu_q", pin.q, 32'd14);
    check("model_divu_r", pin.r, 32'd2);
    pin = model_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    check("model_div_neg_q", pin.q, 32'hFFFF_FFFD);
    check("model_div_neg_r", pin.r, 32'hFFFF_FFFF);
    pin = model_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("model_ovf_q", pin.q, 32'h8000_0000);

    // Reset state.
    check("reset_busy", {31'd0, busy}, '0);
    check("reset_done", {31'd0, done}, '0);
    check("reset_q", quotient, '0);
    check("reset_r", remainder, '0);
    check("reset_dz", {31'd0, div_by_zero}, '0);

    // Directed literal cases.
    run_op("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34);
    run_op("div_zero", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    run_op("divu_max", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);

    // Back-to-back: second start in the DONE cycle of the first.
    run_op("b2b_first", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);
    issue(32'd1000, 32'd10, 1'b0);
    wait_done(1, lat, bcnt);
    check("b2b_lat", lat, 34);
    check("b2b_q", quotient, 32'd100);
    check("b2b_r", remainder, 32'd0);

    // start while busy is ignored.
    next_cycle();
    issue(32'd200, 32'd9, 1'b0);
    repeat (4) next_cycle();
    issue(32'd77, 32'd7, 1'b0);
    wait_done(6, lat, bcnt);
    check("ignore_lat", lat, 34);
    check("ignore_q", quotient, 32'd22);
    check("ignore_r", remainder, 32'd2);

    // Flush mid-run: no done, results held.
    next_cycle();
    issue(32'd999, 32'd3, 1'b0);
    repeat (9) next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, '0);
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) saw_done++;
      next_cycle();
    end
    check("flush_no_done", saw_done, 0);
    check("flush_q_held", quotient, 32'd22);
    check("flush_r_held", remainder, 32'd2);

    // Reset mid-operation.
    issue(32'd12345, 32'd11, 1'b0);
    repeat (4) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, '0);
    check("midrst_q", quotient, '0);
    check("midrst_r", remainder, '0);
    check("midrst_dz", {31'd0, div_by_zero}, '0);

    // Randomized stream checked every cycle by the model.
    for (int c = 0; c < 40000; c++) begin
      rst       = ($urandom_range(0, 2999) == 0);
      flush     = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 3) != 0);
      is_signed = $urandom_range(0, 1);
      dividend  = rand_opnd();
      divisor   = ($urandom_range(0, 9) == 0) ? '0 : rand_opnd();
      next_cycle();
    end
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    repeat (50) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
